apb_cmd_master: RTL and testbench

- Upstream stage of the APB PWM peripheral: the APB requester that drives PADDR/PWRITE/PSEL/PENABLE/PWDATA into the PWM slave and waits on its PREADY.
- Local logic (CPU shim or test sequencer) pushes simple read/write commands through a valid/ready port.
- Commands are buffered in a small FIFO, executed one at a time as APB SETUP/ACCESS transfers, and each returns a one-cycle response with read data or a timeout error.

---
 rtl/apb_master_pkg.sv | 28 ++
 rtl/apb_cmd_fifo.sv | 69 ++++++
 rtl/apb_cmd_master.sv | 184 ++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// -----------------------------------------------------------------------------
// apb_master_pkg
// Shared types and constants for the APB command master:
//   - apb_state_e : requester FSM states (IDLE / SETUP / ACCESS)
//   - apb_cmd_t   : buffered command {write, addr, wdata}
//   - TIMEOUT_DEFAULT : default PREADY wait limit in ACCESS cycles
// Command fields are stored at CMD_AW / CMD_DW bits; the master supports
// ADDR_W <= CMD_AW and DATA_W <= CMD_DW.
// -----------------------------------------------------------------------------
package apb_master_pkg;

    localparam int unsigned CMD_AW          = 32;
    localparam int unsigned CMD_DW          = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [CMD_AW-1:0] addr;
        logic [CMD_DW-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// -----------------------------------------------------------------------------
// apb_cmd_fifo
// Synchronous command FIFO, DEPTH entries (power of two, >= 2).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data    write request and command; ignored while full
//   i_pop             read request; ignored while empty
//   o_data            head entry (valid while !o_empty)
//   o_full, o_empty   occupancy flags, from registered state
// -----------------------------------------------------------------------------
module apb_cmd_fifo
    import apb_master_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_push,
    input  apb_cmd_t i_data,
    input  logic     i_pop,
    output apb_cmd_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    apb_cmd_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
// APB requester: buffers read/write commands from a valid/ready port in a
// FIFO and executes them one at a time as APB SETUP/ACCESS transfers, with a
// PREADY timeout. Each transfer ends with a one-cycle response pulse.
// Ports:
//   PCLK, PRESET                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready = FIFO not full)
//   cmd_write, cmd_addr, cmd_wdata   command payload
//   rsp_valid, rsp_err, rsp_rdata    completion pulse, timeout flag, read data
//   PADDR, PWRITE, PSEL, PENABLE,
//   PWDATA, PREADY, PRDATA           APB requester interface
// Optional feature (macro APB_MASTER_STATS_EN):
//   stat_ok_cnt, stat_err_cnt        saturating 16-bit completion counters
// -----------------------------------------------------------------------------
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
`ifdef APB_MASTER_STATS_EN
    ,
    output logic [15:0]       stat_ok_cnt,
    output logic [15:0]       stat_err_cnt
`endif
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LP_WAIT_LAST = CW'(TIMEOUT - 1);

    apb_state_e        r_state;
    logic              r_rst_q;
    logic              r_avail;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic [CW-1:0]     r_wait;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    apb_cmd_t          w_push_cmd;
    apb_cmd_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_done_ok;
    logic              w_done_err;

    // r_rst_q holds cmd_ready low for every cycle PRESET was sampled high.
    assign cmd_ready = !w_full && !r_rst_q;
    assign w_push    = cmd_valid && cmd_ready;

    // r_avail is the FIFO's non-empty flag one cycle late, so a fresh push
    // reaches IDLE only in the cycle after it lands (no bypass).
    assign w_pop      = (r_state == ST_IDLE) && r_avail && !w_empty;
    assign w_done_ok  = (r_state == ST_ACCESS) && PREADY;
    assign w_done_err = (r_state == ST_ACCESS) && !PREADY && (r_wait == LAST_CHECK());

    function automatic logic [CW-1:0] LAST_CHECK();
        return LP_WAIT_LAST;
    endfunction

    always_comb begin
        w_push_cmd       = '0;
        w_push_cmd.write = cmd_write;
        w_push_cmd.addr  = CMD_AW'(cmd_addr);
        w_push_cmd.wdata = CMD_DW'(cmd_wdata);
    end

    apb_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= ST_IDLE;
            r_rst_q     <= 1'b1;
            r_avail     <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_wait      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rst_q     <= 1'b0;
            r_avail     <= !w_empty;
            r_rsp_valid <= w_done_ok || w_done_err;
            r_rsp_err   <= w_done_err;
            r_rsp_rdata <= (w_done_ok && !r_pwrite) ? PRDATA : '0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_paddr  <= w_head.addr[ADDR_W-1:0];
                        r_pwrite <= w_head.write;
                        r_pwdata <= w_head.wdata[DATA_W-1:0];
                        r_wait   <= '0;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!PREADY) begin
                        r_wait <= r_wait + 1'b1;
                    end
                    // PREADY takes priority over a coincident timeout.
                    if (w_done_ok || w_done_err) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign PSEL      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign PENABLE   = (r_state == ST_ACCESS);
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

`ifdef APB_MASTER_STATS_EN
    logic [15:0] r_stat_ok_cnt;
    logic [15:0] r_stat_err_cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_stat_ok_cnt  <= '0;
            r_stat_err_cnt <= '0;
        end else begin
            if (w_done_ok && (r_stat_ok_cnt != '1)) begin
                r_stat_ok_cnt <= r_stat_ok_cnt + 1'b1;
            end
            if (w_done_err && (r_stat_err_cnt != '1)) begin
                r_stat_err_cnt <= r_stat_err_cnt + 1'b1;
            end
        end
    end

    assign stat_ok_cnt  = r_stat_ok_cnt;
    assign stat_err_cnt = r_stat_err_cnt;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
// Bench for apb_cmd_master. A transaction-level model keeps a queue of
// accepted commands, each tagged with the slave latency to emulate (ACCESS
// cycle on which PREADY rises, 0 = never) and the read data to return.
// The expected response follows from the transfer rules: error when PREADY
// is not seen within TIMEOUT ACCESS cycles, read data only on OK reads.
// -----------------------------------------------------------------------------
module tb_apb_cmd_master;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY = 1'b0;
    logic [DATA_W-1:0] PRDATA = '0;
`ifdef APB_MASTER_STATS_EN
    logic [15:0]       stat_ok_cnt;
    logic [15:0]       stat_err_cnt;
`endif

    always #5 PCLK = ~PCLK;

    apb_cmd_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
`ifdef APB_MASTER_STATS_EN
        ,
        .stat_ok_cnt  (stat_ok_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    bit          active  = 1'b0;
    bit          done    = 1'b0;
    int          acc_n   = 0;
    logic        exp_err;
    logic [31:0] exp_rdata;

    // Bus monitor and PWM-slave model, evaluated away from the active edge.
    always @(negedge PCLK) begin
        if (PRESET || !mon_en) begin
            active = 1'b0;
            done   = 1'b0;
            acc_n  = 0;
            PREADY = 1'b0;
            PRDATA = '0;
        end else begin
            if (done) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL rsp: got valid=%b err=%b rdata=%h, want valid=1 err=%b rdata=%h",
                             rsp_valid, rsp_err, rsp_rdata, exp_err, exp_rdata);
                end
                n_tests++;
                if (PSEL !== 1'b0) begin
                    n_fail++;
                    $display("FAIL turnaround: PSEL=%b after completion, want 0", PSEL);
                end
                done   = 1'b0;
                active = 1'b0;
            end else if (rsp_valid !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_rsp: rsp_valid=%b, want 0", rsp_valid);
            end

            PREADY = 1'b0;
            if (PSEL === 1'b1 && PENABLE === 1'b0) begin
                n_tests++;
                if (active || exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL setup: unexpected SETUP (active=%0d queued=%0d), want none",
                             active, exp_q.size());
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    acc_n  = 0;
                    if (PADDR !== cur.a || PWRITE !== cur.w || PWDATA !== cur.d) begin
                        n_fail++;
                        $display("FAIL order: got addr=%h wr=%b wdata=%h, want addr=%h wr=%b wdata=%h",
                                 PADDR, PWRITE, PWDATA, cur.a, cur.w, cur.d);
                    end
                end
            end else if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                acc_n++;
                n_tests++;
                if (!active) begin
                    n_fail++;
                    $display("FAIL access: ACCESS cycle %0d without SETUP / past completion", acc_n);
                end else begin
                    if (PADDR !== cur.a || PWRITE !== cur.w || PWDATA !== cur.d) begin
                        n_fail++;
                        $display("FAIL stable: got addr=%h wr=%b wdata=%h, want addr=%h wr=%b wdata=%h",
                                 PADDR, PWRITE, PWDATA, cur.a, cur.w, cur.d);
                    end
                    PREADY = (cur.lat != 0 && acc_n == cur.lat);
                    PRDATA = PREADY ? cur.rd : $urandom();
                    if (PREADY || acc_n == int'(TIMEOUT)) begin
                        done      = 1'b1;
                        exp_err   = !PREADY;
                        exp_rdata = (PREADY && !cur.w) ? cur.rd : 32'h0;
                    end
                end
            end else if (PENABLE !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL penable: PENABLE=%b with PSEL=%b, want 0", PENABLE, PSEL);
            end
        end
    end

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int lat, input logic [31:0] rd);
        exp_t e;
        bit   rdy;
        int   g;
        e.w = w; e.a = a; e.d = d; e.lat = lat; e.rd = rd;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        g = 0;
        forever begin
            rdy = cmd_ready;
            @(posedge PCLK);
            if (rdy) begin
                exp_q.push_back(e);
                break;
            end
            @(negedge PCLK);
            g++;
            if (g > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL push_timeout: cmd_ready=%b for 200 cycles, want 1", cmd_ready);
                break;
            end
        end
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while ((exp_q.size() != 0 || active || done) && g < 600) begin
            @(negedge PCLK);
            g++;
        end
        @(negedge PCLK);
        n_tests++;
        if (g >= 600) begin
            n_fail++;
            $display("FAIL drain_timeout: queued=%0d active=%0d, want 0/0", exp_q.size(), active);
        end
    endtask

    task automatic apply_reset();
        @(negedge PCLK);
        mon_en    = 1'b0;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        mon_en = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_reset();
        @(negedge PCLK);
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        n_tests++;
        if (cmd_ready !== 1'b0 || PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 ||
            PADDR !== '0 || PWDATA !== '0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: rdy=%b psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b re=%b rd=%h, want all 0",
                     cmd_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_rdata);
        end
        PRESET = 1'b0;
        @(negedge PCLK);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: cmd_ready=%b after reset release, want 1", cmd_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_write_latency();
        apply_reset();
        push_cmd(1'b1, 32'h1, 32'h40, 2, $urandom());
        n_tests++;
        if (PSEL !== 1'b0) begin
            n_fail++; $display("FAIL lat_n0: PSEL=%b, want 0", PSEL);
        end
        @(negedge PCLK);
        n_tests++;
        if (PSEL !== 1'b0) begin
            n_fail++; $display("FAIL lat_n1: PSEL=%b, want 0", PSEL);
        end
        @(negedge PCLK);
        n_tests++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin
            n_fail++; $display("FAIL lat_n2: PSEL=%b PENABLE=%b, want 1/0", PSEL, PENABLE);
        end
        @(negedge PCLK);
        n_tests++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            n_fail++; $display("FAIL lat_n3: PSEL=%b PENABLE=%b, want 1/1", PSEL, PENABLE);
        end
        wait_done();
    endtask

    task automatic test_timeout();
        push_cmd(1'b0, 32'h2, $urandom(), 0, $urandom());
        wait_done();
        // PREADY on the very last allowed cycle must still complete OK.
        push_cmd(1'b0, 32'h3, $urandom(), int'(TIMEOUT), 32'h1234_5678);
        wait_done();
    endtask

    task automatic test_read_data();
        push_cmd(1'b0, 32'h4, $urandom(), 1, 32'hDEAD_BEEF);
        wait_done();
    endtask

    task automatic test_back_to_back();
        int g = 0;
        push_cmd(1'b1, $urandom(), $urandom(), 0, $urandom());
        while (!(PSEL === 1'b1 && PENABLE === 1'b1) && g < 50) begin
            @(negedge PCLK);
            g++;
        end
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'($urandom()), $urandom(), $urandom(), $urandom_range(0, 4), $urandom());
        end
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full: cmd_ready=%b after 4 pushes, want 0", cmd_ready);
        end
        push_cmd(1'($urandom()), $urandom(), $urandom(), $urandom_range(1, 3), $urandom());
        wait_done();
    endtask

    task automatic test_reset_mid();
        int g = 0;
        bit quiet = 1'b1;
        push_cmd(1'b1, $urandom(), $urandom(), 0, $urandom());
        push_cmd(1'b0, $urandom(), $urandom(), 1, $urandom());
        push_cmd(1'b0, $urandom(), $urandom(), 1, $urandom());
        while (!(PSEL === 1'b1 && PENABLE === 1'b1) && g < 50) begin
            @(negedge PCLK);
            g++;
        end
        mon_en = 1'b0;
        exp_q.delete();
        PRESET = 1'b1;
        @(negedge PCLK);
        n_tests++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: psel=%b pen=%b rv=%b rdy=%b, want 0/0/0/0",
                     PSEL, PENABLE, rsp_valid, cmd_ready);
        end
        PRESET = 1'b0;
        @(negedge PCLK);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ready: cmd_ready=%b after release, want 1", cmd_ready);
        end
        repeat (8) begin
            if (PSEL !== 1'b0 || rsp_valid !== 1'b0) quiet = 1'b0;
            @(negedge PCLK);
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL mid_flush: bus/response activity after reset, want none");
        end
        mon_en = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            push_cmd(1'($urandom()), $urandom(), $urandom(),
                     $urandom_range(0, TIMEOUT + 2), $urandom());
            repeat ($urandom_range(0, 3)) @(negedge PCLK);
        end
        wait_done();
    endtask

`ifdef APB_MASTER_STATS_EN
    task automatic test_stats();
        apply_reset();
        n_tests++;
        if (stat_ok_cnt !== 16'd0 || stat_err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_reset: ok=%0d err=%0d, want 0/0", stat_ok_cnt, stat_err_cnt);
        end
        push_cmd(1'b1, 32'h10, $urandom(), 1, $urandom());
        push_cmd(1'b0, 32'h11, $urandom(), 0, $urandom());
        push_cmd(1'b0, 32'h12, $urandom(), 3, $urandom());
        push_cmd(1'b1, 32'h13, $urandom(), 0, $urandom());
        push_cmd(1'b1, 32'h14, $urandom(), 2, $urandom());
        wait_done();
        n_tests++;
        if (stat_ok_cnt !== 16'd3 || stat_err_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL stats_cnt: ok=%0d err=%0d, want 3/2", stat_ok_cnt, stat_err_cnt);
        end
        force dut.r_stat_ok_cnt = 16'hFFFF;
        @(negedge PCLK);
        release dut.r_stat_ok_cnt;
        push_cmd(1'b1, 32'h15, $urandom(), 1, $urandom());
        wait_done();
        n_tests++;
        if (stat_ok_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_sat: ok=%h, want ffff", stat_ok_cnt);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_latency();
        test_timeout();
        test_read_data();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef APB_MASTER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
